// File: rtl/toy_mcore_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : toy_vpack (package)
//  Brief    : Shared vector geometry, state encoding and depth constant for
//             the toy_mcore feeder.
//  Revision : 1.0  initial release
// ============================================================================
package toy_vpack;

    localparam int V_ELEMENT_NUM = 4;
    localparam int V_REG_WIDTH   = 8;
    localparam int FEED_DEPTH    = 8;

    // One element per array row/column, element 0 in the low bits.
    typedef logic [V_ELEMENT_NUM-1:0][V_REG_WIDTH-1:0] v_vec_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        LOAD   = 3'd3,
        SHIFT  = 3'd4,
        DONE   = 3'd5
    } feed_state_e;

endpackage
`default_nettype wire

// File: rtl/toy_mcore_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : toy_mcore_feeder_if
//  Brief    : Beat input stream plus array-side drive signals of the feeder.
//             slave = feeder view, master = producer/array view.
//  Revision : 1.0  initial release
// ============================================================================
interface toy_mcore_feeder_if;
    import toy_vpack::*;

    logic                     in_valid;
    logic                     in_ready;
    v_vec_t                   in_x;
    v_vec_t                   in_y;
    logic                     in_last;
    v_vec_t                   din;
    logic [V_ELEMENT_NUM-1:0] din_en;
    v_vec_t                   din_y;
    logic [V_ELEMENT_NUM-1:0] load_en;
    logic [V_ELEMENT_NUM-1:0] shift_en;
    logic                     done;
    logic                     ovf_err;

    modport slave (
        input  in_valid, in_x, in_y, in_last,
        output in_ready, din, din_en, din_y, load_en, shift_en, done, ovf_err
    );

    modport master (
        output in_valid, in_x, in_y, in_last,
        input  in_ready, din, din_en, din_y, load_en, shift_en, done, ovf_err
    );

endinterface
`default_nettype wire

// File: rtl/toy_mcore_feeder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : toy_feed_buf
//  Brief    : DEPTH-entry x/y tile register file, one write port and one
//             independent read index per row (x) and per column (y).
//  Revision : 1.0  initial release
// ============================================================================
module toy_feed_buf
    import toy_vpack::*;
#(
    parameter int DEPTH = FEED_DEPTH,
    parameter int A_W   = 3
) (
    input  wire logic                                clk,
    input  wire logic                                rst_n,
    input  wire logic                                we,
    input  wire logic [A_W-1:0]                      waddr,
    input  wire v_vec_t                              wx,
    input  wire v_vec_t                              wy,
    input  wire logic [V_ELEMENT_NUM-1:0][A_W-1:0]   rx_idx,
    input  wire logic [V_ELEMENT_NUM-1:0][A_W-1:0]   ry_idx,
    output v_vec_t                                   rx,
    output v_vec_t                                   ry
);

    v_vec_t r_mem_x [DEPTH];
    v_vec_t r_mem_y [DEPTH];

    // Beat storage; cleared on reset so a discarded tile leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
            end
        end else if (we) begin
            r_mem_x[waddr] <= wx;
            r_mem_y[waddr] <= wy;
        end
    end

    // Lane r only ever needs element r of the beat it is pointed at.
    for (genvar r = 0; r < V_ELEMENT_NUM; r++) begin : g_rd
        assign rx[r] = r_mem_x[rx_idx[r]][r];
        assign ry[r] = r_mem_y[ry_idx[r]][r];
    end

endmodule
`default_nettype wire

// File: rtl/toy_mcore_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : toy_mcore_feeder
//  Brief    : Buffers a K-beat tile, replays it diagonally skewed into the
//             systolic array, then sequences load/shift drain and pulses done.
//             Optional macro TOY_FEEDER_PERF_EN adds perf_cycles/perf_tiles.
//  Revision : 1.0  initial release
// ============================================================================
module toy_mcore_feeder
    import toy_vpack::*;
#(
    parameter int DEPTH = FEED_DEPTH
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    toy_mcore_feeder_if.slave  bus
`ifdef TOY_FEEDER_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [15:0]        perf_tiles
`endif
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int T_W   = $clog2(DEPTH + V_ELEMENT_NUM);
    localparam int S_W   = $clog2(V_ELEMENT_NUM + 1);

    feed_state_e              r_state;
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_k;
    logic [T_W-1:0]           r_t;
    logic [S_W-1:0]           r_s;
    logic                     r_in_ready;
    v_vec_t                   r_din;
    v_vec_t                   r_din_y;
    logic [V_ELEMENT_NUM-1:0] r_din_en;
    logic [V_ELEMENT_NUM-1:0] r_load_en;
    logic [V_ELEMENT_NUM-1:0] r_shift_en;
    logic                     r_done;
    logic                     r_ovf;

    logic                                w_acc;
    logic                                w_close;
    logic [A_W-1:0]                      w_waddr;
    logic [PTR_W-1:0]                    w_wptr_nx;
    logic [T_W-1:0]                      w_t_last;
    logic [V_ELEMENT_NUM-1:0]            w_hit;
    logic [V_ELEMENT_NUM-1:0][T_W-1:0]   w_dx;
    logic [V_ELEMENT_NUM-1:0][A_W-1:0]   w_idx;
    v_vec_t                              w_rx;
    v_vec_t                              w_ry;
    v_vec_t                              w_din_nx;
    v_vec_t                              w_din_y_nx;

    // in_ready is only ever high in IDLE/FILL, so it doubles as the write qualifier.
    assign w_acc     = bus.in_valid && r_in_ready;
    assign w_waddr   = (r_state == IDLE) ? '0 : r_wptr[A_W-1:0];
    assign w_wptr_nx = (r_state == IDLE) ? PTR_W'(1) : r_wptr + PTR_W'(1);
    assign w_close   = w_acc && (bus.in_last || (w_wptr_nx == PTR_W'(DEPTH)));
    assign w_t_last  = T_W'(r_k) + T_W'(V_ELEMENT_NUM - 2);

    // Lane r sees beat t-r; rows and columns share the same skew.
    for (genvar r = 0; r < V_ELEMENT_NUM; r++) begin : g_lane
        assign w_dx[r]       = r_t - T_W'(r);
        assign w_hit[r]      = (r_t >= T_W'(r)) && (w_dx[r] < T_W'(r_k));
        assign w_idx[r]      = w_dx[r][A_W-1:0];
        assign w_din_nx[r]   = w_hit[r] ? w_rx[r] : '0;
        assign w_din_y_nx[r] = w_hit[r] ? w_ry[r] : '0;
    end

    toy_feed_buf #(
        .DEPTH (DEPTH),
        .A_W   (A_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_acc),
        .waddr  (w_waddr),
        .wx     (bus.in_x),
        .wy     (bus.in_y),
        .rx_idx (w_idx),
        .ry_idx (w_idx),
        .rx     (w_rx),
        .ry     (w_ry)
    );

    // Tile sequencer; every array-facing output is registered from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_k        <= '0;
            r_t        <= '0;
            r_s        <= '0;
            r_in_ready <= 1'b0;
            r_din      <= '0;
            r_din_y    <= '0;
            r_din_en   <= '0;
            r_load_en  <= '0;
            r_shift_en <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_din      <= '0;
            r_din_y    <= '0;
            r_din_en   <= '0;
            r_load_en  <= '0;
            r_shift_en <= '0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE, FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_acc) begin
                        r_wptr  <= w_wptr_nx;
                        r_state <= FILL;
                        if (w_close) begin
                            r_k        <= w_wptr_nx;
                            r_t        <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= STREAM;
                            // Closing on the depth limit rather than in_last means truncation.
                            if (!bus.in_last) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                end
                STREAM: begin
                    r_din    <= w_din_nx;
                    r_din_y  <= w_din_y_nx;
                    r_din_en <= w_hit;
                    r_t      <= r_t + T_W'(1);
                    if (r_t == w_t_last) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_load_en <= '1;
                    r_s       <= '0;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    // Chain is V_ELEMENT_NUM cells plus the tail register.
                    r_shift_en <= '1;
                    r_s        <= r_s + S_W'(1);
                    if (r_s == S_W'(V_ELEMENT_NUM)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_in_ready <= 1'b1;
                    r_wptr     <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.din      = r_din;
    assign bus.din_y    = r_din_y;
    assign bus.din_en   = r_din_en;
    assign bus.load_en  = r_load_en;
    assign bus.shift_en = r_shift_en;
    assign bus.done     = r_done;
    assign bus.ovf_err  = r_ovf;

`ifdef TOY_FEEDER_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [15:0] r_perf_tiles;

    // Busy-cycle counter saturates; tile counter wraps on each done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_tiles  <= '0;
        end else begin
            if ((r_state != IDLE) && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (r_done) begin
                r_perf_tiles <= r_perf_tiles + 16'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_tiles  = r_perf_tiles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_toy_mcore_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toy_mcore_feeder
//  Brief    : Randomized self-checking bench for toy_mcore_feeder against a
//             tile-level timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_toy_mcore_feeder;
    import toy_vpack::*;

    localparam int V = V_ELEMENT_NUM;
    localparam int D = FEED_DEPTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    toy_mcore_feeder_if bus ();

`ifdef TOY_FEEDER_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_tiles;
`endif

    toy_mcore_feeder #(.DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave)
`ifdef TOY_FEEDER_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_tiles  (perf_tiles)
`endif
    );

    int     n_checks = 0;
    int     n_errors = 0;
    v_vec_t bx [D];
    v_vec_t by [D];
    int     tile_k;
    logic   exp_ovf;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Element r of the vector at replay step t comes from beat t-r, if it exists.
    function automatic v_vec_t model_vec(input int t, input bit use_y);
        v_vec_t v = '0;
        for (int r = 0; r < V; r++) begin
            if ((t - r >= 0) && (t - r < tile_k)) begin
                v[r] = use_y ? by[t - r][r] : bx[t - r][r];
            end
        end
        return v;
    endfunction

    function automatic logic [V-1:0] model_en(input int t);
        logic [V-1:0] e = '0;
        for (int r = 0; r < V; r++) begin
            e[r] = (t - r >= 0) && (t - r < tile_k);
        end
        return e;
    endfunction

    task automatic rand_tile(input int n);
        for (int i = 0; i < n; i++) begin
            bx[i] = v_vec_t'($urandom);
            by[i] = v_vec_t'($urandom);
        end
    endtask

    // Present nb beats with gap idle cycles between them; returns just after the last accept edge.
    task automatic drive_tile(input int nb, input int gap, input bit last_final);
        int guard;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_x     = bx[i];
            bus.in_y     = by[i];
            bus.in_last  = last_final && (i == nb - 1);
            guard = 0;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_val("ready_wait", 64'(guard < 100), 64'd1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (i < nb - 1) repeat (gap) @(posedge clk);
        end
        tile_k = nb;
    endtask

    // Cycle j after the closing beat: outputs for step j-2, then load, shift, done.
    task automatic check_timeline();
        int k;
        int total;
        logic ld, sh, dn;
        logic [2*V+1:0] exp_ctl;
        k     = tile_k;
        total = k + 2 * V + 3;
        for (int j = 1; j <= total; j++) begin
            @(negedge clk);
            ld = (j == k + V + 1);
            sh = (j >= k + V + 2) && (j <= k + 2 * V + 2);
            dn = (j == total);
            exp_ctl = {{V{ld}}, {V{sh}}, dn, dn};
            check_val($sformatf("din k%0d j%0d", k, j), 64'(bus.din), 64'(model_vec(j - 2, 1'b0)));
            check_val($sformatf("din_y k%0d j%0d", k, j), 64'(bus.din_y), 64'(model_vec(j - 2, 1'b1)));
            check_val($sformatf("din_en k%0d j%0d", k, j), 64'(bus.din_en), 64'(model_en(j - 2)));
            check_val($sformatf("ctl k%0d j%0d", k, j),
                      64'({bus.load_en, bus.shift_en, bus.done, bus.in_ready}), 64'(exp_ctl));
        end
        check_val("ovf_err", 64'(bus.ovf_err), 64'(exp_ovf));
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, " din"}, 64'(bus.din), 64'd0);
        check_val({tag, " din_y"}, 64'(bus.din_y), 64'd0);
        check_val({tag, " ctl"},
                  64'({bus.din_en, bus.load_en, bus.shift_en, bus.done, bus.in_ready, bus.ovf_err}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        v_vec_t nine_x, nine_y;
        int     k;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_last  = 1'b0;
        exp_ovf      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat: row r carries r+1, column c carries c+5.
        bx[0] = 32'h04030201;
        by[0] = 32'h08070605;
        drive_tile(1, 0, 1'b1);
        check_timeline();

        // K=3 with x element r of beat k equal to k*16+r.
        rand_tile(3);
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < V; r++)
                bx[b][r] = 8'(b * 16 + r);
        drive_tile(3, 0, 1'b1);
        check_timeline();

        // Same tile with 3-cycle input gaps and then gap-free must replay identically.
        rand_tile(5);
        drive_tile(5, 3, 1'b1);
        check_timeline();
        drive_tile(5, 0, 1'b1);
        check_timeline();

        // in_last exactly on beat DEPTH is not an overflow.
        rand_tile(D);
        drive_tile(D, 0, 1'b1);
        check_timeline();

        // Random tile sizes and gaps.
        for (int it = 0; it < 3; it++) begin
            k = $urandom_range(1, D);
            rand_tile(k);
            drive_tile(k, $urandom_range(0, 2), 1'b1);
            check_timeline();
        end

        // Nine beats without in_last: truncation at DEPTH, ninth beat becomes its own tile.
        rand_tile(D);
        nine_x = v_vec_t'($urandom);
        nine_y = v_vec_t'($urandom);
        drive_tile(D, 0, 1'b0);
        exp_ovf = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_x     = nine_x;
        bus.in_y     = nine_y;
        bus.in_last  = 1'b1;
        check_timeline();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bx[0]  = nine_x;
        by[0]  = nine_y;
        tile_k = 1;
        check_timeline();

        // Reset in the middle of SHIFT.
        rand_tile(2);
        drive_tile(2, 0, 1'b1);
        repeat (2 + V + 3) @(negedge clk);
        check_val("pre_reset shift_en", 64'(bus.shift_en), 64'({V{1'b1}}));
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_tile(4);
        drive_tile(4, 1, 1'b1);
        check_timeline();

`ifdef TOY_FEEDER_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_tile(2);
        drive_tile(2, 0, 1'b1);
        check_timeline();
        rand_tile(2);
        drive_tile(2, 0, 1'b1);
        check_timeline();
        @(posedge clk);
        #1;
        check_val("perf_tiles", 64'(perf_tiles), 64'd2);
        check_val("perf_cycles", 64'(perf_cycles), 64'(2 * ((2 - 1) + (2 + V - 1) + 1 + (V + 1) + 1)));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toy_mcore_feeder.md
Name: toy_mcore_feeder

Overview:
- Upstream stage of the toy_mcore systolic array.
- Accepts a tile of K input beats over a valid/ready stream and buffers it. Each beat carries one x vector (row-edge data) and one y vector (column-edge data).
- Replays the tile diagonally skewed: row r and column c are delayed r and c cycles respectively.
- Then sequences the load and shift controls that drain results out of the array's shift chain, and pulses done.

Parameters:
- DEPTH, 8, max beats per tile (K ≤ DEPTH); pointer width $clog2(DEPTH+1).
- V_ELEMENT_NUM and V_REG_WIDTH come from toy_vpack and are not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_x  in  V_REG_WIDTH x [V_ELEMENT_NUM]  x vector, element r goes to row r
- in_y  in  V_REG_WIDTH x [V_ELEMENT_NUM]  y vector, element c goes to column c
- in_last  in  1  final beat of tile
- din  out  V_REG_WIDTH x [V_ELEMENT_NUM]  to array row inputs
- din_en  out  1 x [V_ELEMENT_NUM]  row data valid
- din_y  out  V_REG_WIDTH x [V_ELEMENT_NUM]  to array column inputs
- load_en  out  1 x [V_ELEMENT_NUM]  capture results into shift chain
- shift_en  out  1 x [V_ELEMENT_NUM]  advance shift chain
- done  out  1  one-cycle pulse at end of tile
- ovf_err  out  1  sticky: tile truncated at DEPTH

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE; all counters 0.
  - din, din_y all 0; din_en, load_en, shift_en all 0.
  - done 0, ovf_err 0, in_ready 0 while rst_n low.
- IDLE:
  - in_ready=1.
  - An accepted beat is written to buf[0], wptr=1, next state FILL.
  - If that beat has in_last, K=1 and next state is STREAM directly.
- FILL:
  - in_ready=1; each accepted beat is written to buf[wptr], wptr++.
  - On an accepted beat with in_last, or when wptr reaches DEPTH: K=wptr (after increment), next state STREAM.
  - Reaching DEPTH without in_last sets ovf_err. Later beats form a new tile.
- STREAM:
  - in_ready=0; cycle counter t runs 0..K+V_ELEMENT_NUM-2.
  - Outputs are registered: values for step t appear on the cycle after t is in state.
  - Row r: if 0 ≤ t-r < K, din[r]=buf[t-r].x[r] and din_en[r]=1; otherwise din[r]=0 and din_en[r]=0.
  - Column c: if 0 ≤ t-c < K, din_y[c]=buf[t-c].y[c]; otherwise 0.
  - The last step moves to LOAD.
- LOAD: one cycle, all load_en=1; din_en=0 and din/din_y=0 from this state onward.
- SHIFT:
  - all shift_en=1 for V_ELEMENT_NUM+1 consecutive cycles (chain length incl. tail register).
  - Then state DONE.
- DONE: done=1 for one cycle, next state IDLE.
- Total latency, first accepted beat to done: K + (K+V_ELEMENT_NUM-1) + 1 + (V_ELEMENT_NUM+1) + 1 + 1 register cycles.
- Boundary conditions:
  - in_valid deasserted mid-FILL: wait indefinitely, no timeout.
  - in_last on beat DEPTH: no ovf_err.
  - load_en and shift_en are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, buffered tile discarded; ovf_err cleared only by reset.

Optional Feature:
- Macro TOY_FEEDER_PERF_EN.
- Defined: adds output perf_cycles [31:0], counting cycles with state≠IDLE (saturating) and cleared on reset only. Adds output perf_tiles [15:0], incremented on done (wrapping).
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- toy_vpack gets:
  - typedef v_vec_t (V_REG_WIDTH x [V_ELEMENT_NUM]);
  - enum feed_state_e {IDLE, FILL, STREAM, LOAD, SHIFT, DONE};
  - localparam FEED_DEPTH=8.
- One sub-module, toy_feed_buf: DEPTH-entry x/y register file with one write port and V_ELEMENT_NUM independent row/column read indices (t-r, t-c). The skew and FSM stay in toy_mcore_feeder.

Test Plan (V_ELEMENT_NUM=4, DEPTH=8):
- Single beat x={1,2,3,4}, y={5,6,7,8}, last=1 -> row r din_en=1 only at STREAM step r with din[r]=r+1; din_y[c]=c+5 at step c; LOAD 1 cycle; SHIFT 5 cycles; done one pulse.
- K=3 tile, beats x=k*16+r -> at step t=3, din = {0x30 invalid→0, 0x21, 0x12, 0x03}, din_en={0,1,1,1}; STREAM lasts 6 cycles.
- 9 beats, no in_last -> tile closes at 8 beats, ovf_err=1; 9th beat accepted after done as new tile.
- in_valid gaps of 3 cycles between beats -> identical din/din_y sequence to gap-free run; in_ready=0 throughout STREAM..DONE.
- rst_n dropped mid-SHIFT -> all outputs 0 asynchronously; next tile after release behaves as from cold reset.
- With TOY_FEEDER_PERF_EN: two K=2 tiles -> perf_tiles=2; perf_cycles=2×(non-IDLE cycles per tile).
